instruction_fetch: RTL and testbench

Drives the program counter from the consumer side: reads `current_address`, fetches the instruction word from instruction memory over a valid/ready handshake, hands it to decode, then writes the next address back into the program counter via `write_enable`/`new_address` and waits for `address_updated`. Sits between the program counter, instruction memory and the decode stage. It is the sole writer of the program counter in the core.

---
 rtl/fetch_pkg.sv | 17 +
 rtl/fetch_timeout.sv | 36 +++
 rtl/instruction_fetch.sv | 122 ++++++++++++
 tb/tb_instruction_fetch.sv | 335 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch unit.
package fetch_pkg;

  typedef enum logic [1:0] {
    S_START,
    S_FETCH,
    S_ISSUE,
    S_UPDATE
  } fetch_state_e;

  localparam int unsigned DEF_INSTR_BYTES    = 4;
  localparam int unsigned DEF_TIMEOUT_CYCLES = 16;

  // Clears the two low address bits; truncate to the address width at the use site.
  localparam logic [63:0] ALIGN_MASK = ~64'h3;

endpackage

// File: rtl/fetch_timeout.sv
// Memory wait watchdog: counts unanswered request cycles and pulses fetch_error on expiry.
module fetch_timeout
  import fetch_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES
) (
  input  logic clk,
  input  logic reset,
  input  logic active,
  input  logic mem_ready,
  output logic expire_c,
  output logic fetch_error
);

  localparam int unsigned CNT_W = $clog2(TIMEOUT_CYCLES + 1);

  logic [CNT_W-1:0] count;

  // Expires on the last waiting cycle unless data arrives in that same cycle.
  assign expire_c = active && !mem_ready && (count == CNT_W'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      count       <= '0;
      fetch_error <= 1'b0;
    end else begin
      fetch_error <= expire_c;
      if (!active || mem_ready || expire_c) begin
        count <= '0;
      end else begin
        count <= count + CNT_W'(1);
      end
    end
  end

endmodule

// File: rtl/instruction_fetch.sv
// Fetch loop: request word at PC, hand it to decode, write the next PC back.
// Optional memory timeout watchdog enabled by defining FETCH_TIMEOUT_EN.
module instruction_fetch
  import fetch_pkg::*;
#(
`ifdef FETCH_TIMEOUT_EN
  parameter int unsigned TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES,
`endif
  parameter int unsigned ADDR_W      = 32,
  parameter int unsigned DATA_W      = 32,
  parameter int unsigned INSTR_BYTES = DEF_INSTR_BYTES
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [ADDR_W-1:0] current_address,
  input  logic              address_updated,
  output logic              write_enable,
  output logic [ADDR_W-1:0] new_address,
  output logic              mem_req,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic              mem_ready,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              instr_valid,
  output logic [DATA_W-1:0] instr,
  input  logic              instr_ready,
  input  logic              branch_taken,
  input  logic [ADDR_W-1:0] branch_target,
  output logic              fetch_error
);

  fetch_state_e      state, state_d;
  logic              mem_req_d, write_enable_d, instr_valid_d;
  logic [ADDR_W-1:0] mem_addr_d, new_address_d;
  logic [DATA_W-1:0] instr_d;
  logic              timeout_c;

`ifdef FETCH_TIMEOUT_EN
  fetch_timeout #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_timeout (
    .clk        (clk),
    .reset      (reset),
    .active     ((state == S_FETCH) && mem_req),
    .mem_ready  (mem_ready),
    .expire_c   (timeout_c),
    .fetch_error(fetch_error)
  );
`else
  assign timeout_c   = 1'b0;
  assign fetch_error = 1'b0;
`endif

  // Next state and next registered outputs.
  always_comb begin
    state_d        = state;
    mem_req_d      = 1'b0;
    mem_addr_d     = mem_addr;
    write_enable_d = 1'b0;
    new_address_d  = new_address;
    instr_valid_d  = 1'b0;
    instr_d        = instr;
    case (state)
      S_START: begin
        state_d    = S_FETCH;
        mem_req_d  = 1'b1;
        mem_addr_d = current_address;
      end
      S_FETCH: begin
        if (mem_req && mem_ready) begin
          instr_d       = mem_rdata;
          instr_valid_d = 1'b1;
          state_d       = S_ISSUE;
        end else begin
          // A timeout drops the request for one cycle, then retries the held address.
          mem_req_d = !timeout_c;
        end
      end
      S_ISSUE: begin
        if (instr_valid && instr_ready) begin
          new_address_d  = branch_taken ? (branch_target & ADDR_W'(ALIGN_MASK))
                                        : current_address + ADDR_W'(INSTR_BYTES);
          write_enable_d = 1'b1;
          state_d        = S_UPDATE;
        end else begin
          instr_valid_d = 1'b1;
        end
      end
      S_UPDATE: begin
        if (address_updated) begin
          // The PC now holds new_address, so fetch from it without waiting a cycle.
          state_d    = S_FETCH;
          mem_req_d  = 1'b1;
          mem_addr_d = new_address;
        end else begin
          write_enable_d = 1'b1;
        end
      end
      default: state_d = S_START;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state        <= S_START;
      mem_req      <= 1'b0;
      mem_addr     <= '0;
      write_enable <= 1'b0;
      new_address  <= '0;
      instr_valid  <= 1'b0;
      instr        <= '0;
    end else begin
      state        <= state_d;
      mem_req      <= mem_req_d;
      mem_addr     <= mem_addr_d;
      write_enable <= write_enable_d;
      new_address  <= new_address_d;
      instr_valid  <= instr_valid_d;
      instr        <= instr_d;
    end
  end

endmodule

// File: tb/tb_instruction_fetch.sv
// Randomized scoreboard bench for instruction_fetch with PC, memory and decode models.
module tb_instruction_fetch;

  localparam int unsigned AW      = 32;
  localparam int unsigned DW      = 32;
  localparam int unsigned TIMEOUT = 16;

  logic          clk = 1'b0;
  logic          reset;
  logic [AW-1:0] current_address;
  logic          address_updated;
  logic          write_enable;
  logic [AW-1:0] new_address;
  logic          mem_req;
  logic [AW-1:0] mem_addr;
  logic          mem_ready;
  logic [DW-1:0] mem_rdata;
  logic          instr_valid;
  logic [DW-1:0] instr;
  logic          instr_ready;
  logic          branch_taken;
  logic [AW-1:0] branch_target;
  logic          fetch_error;

  instruction_fetch dut (
    .clk            (clk),
    .reset          (reset),
    .current_address(current_address),
    .address_updated(address_updated),
    .write_enable   (write_enable),
    .new_address    (new_address),
    .mem_req        (mem_req),
    .mem_addr       (mem_addr),
    .mem_ready      (mem_ready),
    .mem_rdata      (mem_rdata),
    .instr_valid    (instr_valid),
    .instr          (instr),
    .instr_ready    (instr_ready),
    .branch_taken   (branch_taken),
    .branch_target  (branch_target),
    .fetch_error    (fetch_error)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a == 32'h0) ? 32'hDEADBEEF : ((a * 32'h9E37_79B9) ^ 32'h1234_5678);
  endfunction

  // Environment knobs
  int lat_lo = 0, lat_hi = 0;
  int upd_lo = 0, upd_hi = 0;
  int rdy_pct = 100, br_pct = 0;
  bit upd_hold = 1'b0;
  bit fixed_tgt_en = 1'b0;
  logic [AW-1:0] fixed_tgt = '0;

  // Program counter model: updated only by acknowledged writes
  logic [AW-1:0] pc;
  always @(posedge clk or negedge reset) begin
    if (!reset) pc <= '0;
    else if (write_enable && address_updated) pc <= new_address;
  end
  assign current_address = pc;

  // Input drivers: memory, decode and PC acknowledge
  int wait_left = 0;
  int upd_left  = 0;
  initial begin
    mem_ready = 1'b0; mem_rdata = '0; instr_ready = 1'b0;
    address_updated = 1'b0; branch_taken = 1'b0; branch_target = '0;
  end
  always @(negedge clk) begin
    if (!reset) begin
      mem_ready = 1'b0; instr_ready = 1'b0; address_updated = 1'b0; branch_taken = 1'b0;
      wait_left = $urandom_range(lat_hi, lat_lo);
      upd_left  = $urandom_range(upd_hi, upd_lo);
    end else begin
      if (mem_req) begin
        if (wait_left == 0) begin
          mem_ready = 1'b1;
          mem_rdata = mem_word(mem_addr);
          wait_left = $urandom_range(lat_hi, lat_lo);
        end else begin
          mem_ready = 1'b0;
          mem_rdata = $urandom;
          wait_left--;
        end
      end else begin
        mem_ready = 1'($urandom_range(1, 0));
        mem_rdata = $urandom;
      end
      instr_ready   = ($urandom_range(99, 0) < rdy_pct);
      branch_taken  = ($urandom_range(99, 0) < br_pct);
      branch_target = fixed_tgt_en ? fixed_tgt : AW'($urandom);
      if (write_enable) begin
        if (upd_left == 0 && !upd_hold) begin
          address_updated = 1'b1;
          upd_left = $urandom_range(upd_hi, upd_lo);
        end else begin
          address_updated = 1'b0;
          if (upd_left > 0) upd_left--;
        end
      end else begin
        address_updated = 1'($urandom_range(1, 0));
      end
    end
  end

  // Monitor / scoreboard
  logic [DW-1:0] iq[$];
  logic [AW-1:0] nq[$];
  logic [AW-1:0] pc_exp, nxt, p_addr, p_new, last_req_addr;
  logic [DW-1:0] p_instr;
  logic p_req, p_rdy, p_ival, p_irdy, p_we, p_upd;
  bit err_pending, retry_pending;
  int wait_cnt;
  int n_commit = 0;
  int n_err_exp = 0;

  always @(negedge clk) begin
    #1;
    if (!reset) begin
      iq.delete(); nq.delete();
      pc_exp = '0;
      {p_req, p_rdy, p_ival, p_irdy, p_we, p_upd} = '0;
      err_pending = 1'b0; retry_pending = 1'b0; wait_cnt = 0;
    end else begin
      if (p_req && !p_rdy && !err_pending) begin
        check("mem_req_hold", mem_req, 1);
        check("mem_addr_stable", mem_addr, p_addr);
      end
      if (p_ival && !p_irdy) begin
        check("instr_valid_hold", instr_valid, 1);
        check("instr_stable", instr, p_instr);
      end
      if (p_we) begin
        check("write_enable_release", write_enable, !p_upd);
        if (!p_upd) check("new_address_stable", new_address, p_new);
      end
      check("one_phase_active", ($countones({mem_req, instr_valid, write_enable}) <= 1), 1);
`ifdef FETCH_TIMEOUT_EN
      check("fetch_error", fetch_error, err_pending);
      if (err_pending) check("timeout_drop_req", mem_req, 0);
      if (retry_pending) begin
        check("retry_req", mem_req, 1);
        check("retry_addr", mem_addr, last_req_addr);
      end
      retry_pending = err_pending;
      err_pending = 1'b0;
      if (mem_req && !mem_ready) begin
        wait_cnt++;
        if (wait_cnt == TIMEOUT) begin
          err_pending = 1'b1;
          wait_cnt = 0;
          n_err_exp++;
        end
      end else begin
        wait_cnt = 0;
      end
`else
      check("fetch_error_tied", fetch_error, 0);
`endif
      if (mem_req) last_req_addr = mem_addr;
      if (mem_req && mem_ready) begin
        check("fetch_addr", mem_addr, pc_exp);
        iq.push_back(mem_word(pc_exp));
      end
      if (instr_valid && instr_ready) begin
        if (iq.size() == 0) begin
          check("instr_unexpected", 1, 0);
        end else begin
          check("instr_data", instr, iq.pop_front());
        end
        nxt = branch_taken ? (branch_target - (branch_target % 4)) : (pc_exp + 4);
        nq.push_back(nxt);
      end
      if (write_enable && address_updated) begin
        if (nq.size() == 0) begin
          check("pc_write_unexpected", 1, 0);
        end else begin
          nxt = nq.pop_front();
          check("new_address", new_address, nxt);
          pc_exp = nxt;
          n_commit++;
        end
      end
      p_req = mem_req; p_rdy = mem_ready; p_addr = mem_addr;
      p_ival = instr_valid; p_irdy = instr_ready; p_instr = instr;
      p_we = write_enable; p_upd = address_updated; p_new = new_address;
    end
  end

  function automatic logic sig_val(input int which);
    case (which)
      0: return write_enable;
      1: return instr_valid;
      default: return fetch_error;
    endcase
  endfunction

  task automatic wait_sig(input int which, input logic lvl, input string name, input int budget);
    int n = 0;
    while (sig_val(which) !== lvl && n < budget) begin
      @(negedge clk); #2;
      n++;
    end
    check(name, sig_val(which), lvl);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  int c0;
  logic [DW-1:0] held;

  initial begin
    reset = 1'b0;
    repeat (3) @(negedge clk);
    #2;
    check("rst_mem_req", mem_req, 0);
    check("rst_mem_addr", mem_addr, 0);
    check("rst_write_enable", write_enable, 0);
    check("rst_new_address", new_address, 0);
    check("rst_instr_valid", instr_valid, 0);
    check("rst_instr", instr, 0);
    check("rst_fetch_error", fetch_error, 0);

    // First instruction with single-cycle memory and PC
    @(posedge clk); #1 reset = 1'b1;
    @(negedge clk); #2;
    check("start_idle_req", mem_req, 0);
    @(negedge clk); #2;
    check("first_req", mem_req, 1);
    check("first_addr", mem_addr, 32'h0);
    @(negedge clk); #2;
    check("first_instr_valid", instr_valid, 1);
    check("first_instr", instr, 32'hDEADBEEF);
    @(negedge clk); #2;
    check("first_we", write_enable, 1);
    check("first_new_address", new_address, 32'h4);
    @(negedge clk); #2;
    check("first_we_drop", write_enable, 0);
    check("second_req", mem_req, 1);
    check("second_addr", mem_addr, 32'h4);

    // Decode stall
    rdy_pct = 0;
    wait_sig(1, 1'b1, "stall_wait_valid", 50);
    held = instr;
    check("stall_instr_value", held, mem_word(32'h4));
    repeat (5) begin
      @(negedge clk); #2;
      check("stall_valid", instr_valid, 1);
      check("stall_instr", instr, held);
      check("stall_no_we", write_enable, 0);
      check("stall_no_req", mem_req, 0);
    end

    // Branch with misaligned target
    br_pct = 100; fixed_tgt_en = 1'b1; fixed_tgt = 32'h0000_1003; rdy_pct = 100;
    wait_sig(0, 1'b1, "branch_wait_we", 50);
    check("branch_new_address", new_address, 32'h0000_1000);

    // Wrap-around at top of address space
    fixed_tgt = 32'hFFFF_FFFE;
    wait_sig(0, 1'b0, "wrap_wait_we_low", 50);
    wait_sig(0, 1'b1, "wrap_wait_we_high", 50);
    check("wrap_branch_address", new_address, 32'hFFFF_FFFC);
    br_pct = 0;
    wait_sig(0, 1'b0, "wrap_wait_we_low2", 50);
    wait_sig(0, 1'b1, "wrap_wait_we_high2", 50);
    check("wrap_new_address", new_address, 32'h0000_0000);
    fixed_tgt_en = 1'b0;

    // Reset in the middle of a PC write
    upd_hold = 1'b1;
    wait_sig(0, 1'b0, "rst_wait_we_low", 50);
    wait_sig(0, 1'b1, "rst_wait_we_high", 50);
    reset = 1'b0;
    #1;
    check("midrst_we", write_enable, 0);
    check("midrst_new_address", new_address, 0);
    check("midrst_instr_valid", instr_valid, 0);
    upd_hold = 1'b0;
    repeat (2) @(posedge clk);
    #1 reset = 1'b1;
    @(negedge clk); #2;
    check("midrst_idle", mem_req, 0);
    @(negedge clk); #2;
    check("midrst_req", mem_req, 1);
    check("midrst_addr", mem_addr, 32'h0);

    // Randomized traffic
    lat_lo = 0; lat_hi = 4; upd_lo = 0; upd_hi = 3; rdy_pct = 70; br_pct = 20;
    c0 = n_commit;
    repeat (3000) @(negedge clk);
    #2;
    check("random_progress", (n_commit - c0) > 100, 1);

`ifdef FETCH_TIMEOUT_EN
    // Memory withheld long enough to expire the watchdog
    lat_lo = 40; lat_hi = 40;
    wait_sig(2, 1'b1, "timeout_wait_error", 400);
    check("timeout_req_dropped", mem_req, 0);
    @(negedge clk); #2;
    check("timeout_error_pulse", fetch_error, 0);
    check("timeout_retry_req", mem_req, 1);
    lat_lo = 10; lat_hi = 20;
    c0 = n_commit;
    repeat (2000) @(negedge clk);
    #2;
    check("timeout_progress", (n_commit - c0) > 10, 1);
    check("timeout_seen", n_err_exp > 1, 1);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
    $finish;
  end

endmodule
